sweep_scheduler: RTL and testbench

Sequences a raster sweep of the sunflower tracker across theta × phi positions. At each point it commands the servo position, waits a settle time, requests one ADC conversion and keeps the running maximum voltage with its angles. After the last point it parks the panel at the best position and reports the result. It sits between the top-level start control, the servo drivers (theta_pos/phi_pos), the ADC front end, and the 7-seg/LED display path.

---
 rtl/sweep_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_sweep_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_scheduler.sv
// -----------------------------------------------------------------------------
// sweep_scheduler
//
// Raster-sweeps the tracker over THETA_STEPS x PHI_STEPS positions with theta
// as the fast index. At each point it commands the servo position, waits
// SETTLE_CYCLES, requests one ADC conversion and keeps the running maximum
// together with its angles. After the last point it parks the panel at the
// best position for SETTLE_CYCLES, pulses done and returns to idle. Results
// and position hold until the next start or reset.
//
// Optional feature macro: SWEEP_TIMEOUT_EN
//   defined   - the ADC wait in SAMPLE is limited to TIMEOUT_CYCLES; a missing
//               conversion is taken as 0 and sets the sticky timeout_err flag.
//   undefined - SAMPLE waits indefinitely and timeout_err is tied low.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        one-cycle sweep request, honoured only when idle
//   adc_data     12-bit ADC code, valid while adc_valid is high
//   adc_valid    one-cycle conversion-complete strobe
//   adc_req      one-cycle conversion request pulse
//   theta_pos    commanded horizontal index
//   phi_pos      commanded vertical index
//   busy         high whenever the scheduler is not idle
//   done         one-cycle pulse at the end of a sweep
//   best_value   largest ADC code seen in the last/current sweep
//   best_theta   theta index of best_value
//   best_phi     phi index of best_value
//   timeout_err  sticky ADC-timeout flag
// -----------------------------------------------------------------------------
module sweep_scheduler #(
  parameter int THETA_STEPS    = 36,
  parameter int PHI_STEPS      = 9,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  output logic        adc_req,
  output logic [7:0]  theta_pos,
  output logic [7:0]  phi_pos,
  output logic        busy,
  output logic        done,
  output logic [11:0] best_value,
  output logic [7:0]  best_theta,
  output logic [7:0]  best_phi,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_SAMPLE,
    S_COMPARE,
    S_PARK,
    S_DONE
  } state_e;

  // The settle counter counts down from SETTLE_CYCLES-1 to 0, giving exactly
  // SETTLE_CYCLES cycles in SETTLE and in PARK.
  localparam int                  SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0]          THETA_LAST  = 8'(THETA_STEPS - 1);
  localparam logic [7:0]          PHI_LAST    = 8'(PHI_STEPS - 1);

  state_e              state_q;
  logic [SETTLE_W-1:0] settle_cnt_q;
  logic [11:0]         sample_q;
  logic                adc_req_q;
  logic [7:0]          theta_q;
  logic [7:0]          phi_q;
  logic                busy_q;
  logic                done_q;
  logic [11:0]         best_value_q;
  logic [7:0]          best_theta_q;
  logic [7:0]          best_phi_q;

`ifdef SWEEP_TIMEOUT_EN
  localparam int                   TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]                tmo_cnt_q;
  logic                            tmo_err_q;
`endif

  // Best-so-far after the current COMPARE. Computed ahead of the register
  // update so that, on the final point, PARK can steer to a maximum found
  // by that very comparison. Strict '>' keeps the earliest point on ties.
  logic        better_d;
  logic [11:0] best_value_d;
  logic [7:0]  best_theta_d;
  logic [7:0]  best_phi_d;

  always_comb begin
    better_d     = (sample_q > best_value_q);
    best_value_d = better_d ? sample_q : best_value_q;
    best_theta_d = better_d ? theta_q  : best_theta_q;
    best_phi_d   = better_d ? phi_q    : best_phi_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      sample_q     <= '0;
      adc_req_q    <= 1'b0;
      theta_q      <= '0;
      phi_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_value_q <= '0;
      best_theta_q <= '0;
      best_phi_q   <= '0;
`ifdef SWEEP_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      tmo_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_MOVE;
            busy_q       <= 1'b1;
            theta_q      <= '0;
            phi_q        <= '0;
            best_value_q <= '0;
            best_theta_q <= '0;
            best_phi_q   <= '0;
`ifdef SWEEP_TIMEOUT_EN
            tmo_err_q    <= 1'b0;
`endif
          end
        end

        // Position outputs already changed on the edge into MOVE.
        S_MOVE: begin
          settle_cnt_q <= SETTLE_LOAD;
          state_q      <= S_SETTLE;
        end

        S_SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_q   <= S_SAMPLE;
            adc_req_q <= 1'b1;  // high for the first SAMPLE cycle only
`ifdef SWEEP_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end else begin
            settle_cnt_q <= settle_cnt_q - 1'b1;
          end
        end

        S_SAMPLE: begin
          adc_req_q <= 1'b0;
          if (adc_valid) begin
            sample_q <= adc_data;
            state_q  <= S_COMPARE;
          end
`ifdef SWEEP_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            sample_q  <= '0;
            tmo_err_q <= 1'b1;
            state_q   <= S_COMPARE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end

        S_COMPARE: begin
          best_value_q <= best_value_d;
          best_theta_q <= best_theta_d;
          best_phi_q   <= best_phi_d;
          if (theta_q < THETA_LAST) begin
            theta_q <= theta_q + 1'b1;
            state_q <= S_MOVE;
          end else if (phi_q < PHI_LAST) begin
            theta_q <= '0;
            phi_q   <= phi_q + 1'b1;
            state_q <= S_MOVE;
          end else begin
            theta_q      <= best_theta_d;
            phi_q        <= best_phi_d;
            settle_cnt_q <= SETTLE_LOAD;
            state_q      <= S_PARK;
          end
        end

        S_PARK: begin
          if (settle_cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q - 1'b1;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          adc_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign adc_req    = adc_req_q;
  assign theta_pos  = theta_q;
  assign phi_pos    = phi_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign best_value = best_value_q;
  assign best_theta = best_theta_q;
  assign best_phi   = best_phi_q;

`ifdef SWEEP_TIMEOUT_EN
  assign timeout_err = tmo_err_q;
`else
  // No timeout hardware; the expression folds to 0 and keeps the limit
  // parameter referenced in this build.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sweep_scheduler
//
// Self-checking bench for sweep_scheduler with a 4 x 2 grid and a 2-cycle
// settle. A table of sweep scenarios (ADC value map, ADC latency, optional
// disturbance, expected best point) is applied in a loop. Expected raster
// positions and the expected result are queued when a sweep is started and
// popped as the DUT issues adc_req / done. Hand-written sequences cover reset
// (including mid-sweep) and, when SWEEP_TIMEOUT_EN is defined, the ADC timeout.
// -----------------------------------------------------------------------------
module tb_sweep_scheduler;

  localparam int THETA_N = 4;
  localparam int PHI_N   = 2;
  localparam int SETTLE  = 2;
  localparam int TMO     = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic        adc_req;
  logic [7:0]  theta_pos;
  logic [7:0]  phi_pos;
  logic        busy;
  logic        done;
  logic [11:0] best_value;
  logic [7:0]  best_theta;
  logic [7:0]  best_phi;
  logic        timeout_err;

  sweep_scheduler #(
    .THETA_STEPS   (THETA_N),
    .PHI_STEPS     (PHI_N),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .adc_req    (adc_req),
    .theta_pos  (theta_pos),
    .phi_pos    (phi_pos),
    .busy       (busy),
    .done       (done),
    .best_value (best_value),
    .best_theta (best_theta),
    .best_phi   (best_phi),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] base;
    logic [7:0]  s1_t;
    logic [7:0]  s1_p;
    logic [11:0] s1_v;
    logic [7:0]  s2_t;
    logic [7:0]  s2_p;
    logic [11:0] s2_v;
    int          lat;      // cycles from adc_req to adc_valid (0 = entry cycle)
    bit          disturb;  // stray adc_valid in MOVE/SETTLE plus start while busy
    logic [11:0] exp_val;
    logic [7:0]  exp_t;
    logic [7:0]  exp_p;
  } vec_t;

  typedef struct packed {
    logic [7:0] t;
    logic [7:0] p;
  } pos_t;

  typedef struct packed {
    logic [11:0] v;
    logic [7:0]  t;
    logic [7:0]  p;
  } res_t;

  pos_t exp_pos_q[$];
  res_t exp_res_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] adc_model(input vec_t v, input logic [7:0] t, input logic [7:0] p);
    if (t == v.s1_t && p == v.s1_p) return v.s1_v;
    if (t == v.s2_t && p == v.s2_p) return v.s2_v;
    return v.base;
  endfunction

  // One full sweep. Called at a negedge with the DUT idle. When silent00 is
  // set the ADC never answers the (0,0) request.
  task automatic run_sweep(input vec_t v, input bit silent00);
    int   busy_cycles = 0;
    int   reqs        = 0;
    int   pend        = -1;
    int   tmo_cnt     = -1;
    int   exp_busy;
    bit   finished    = 0;
    logic [11:0] pend_data = '0;
    pos_t ep;
    res_t er;
    res_t cur_res;

    for (int p = 0; p < PHI_N; p++)
      for (int t = 0; t < THETA_N; t++)
        exp_pos_q.push_back('{t: 8'(t), p: 8'(p)});
    exp_res_q.push_back('{v: v.exp_val, t: v.exp_t, p: v.exp_p});
    cur_res = '{v: v.exp_val, t: v.exp_t, p: v.exp_p};

    exp_busy = THETA_N * PHI_N * (1 + SETTLE + (v.lat + 1) + 1) + SETTLE + 1;
    if (silent00) exp_busy += TMO - (v.lat + 1);

    // NOTE: bench inputs are driven with blocking assignments at the negedge,
    // well away from the sampling posedge.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      adc_valid = 1'b0;
      start     = 1'b0;
      if (cyc == 0) begin
        check("start_busy", busy, 1);
        check("start_clear_best", best_value, 0);
        check("start_clear_err", timeout_err, 0);
      end
      if (busy) busy_cycles++;

      if (tmo_cnt >= 0) begin
        tmo_cnt++;
        if (theta_pos == 8'd1) begin
          check("timeout_sample_len", tmo_cnt, TMO + 1);
          check("timeout_flag_set", timeout_err, 1);
          tmo_cnt = -1;
        end
      end

      if (v.disturb && busy_cycles >= 1 && busy_cycles <= SETTLE + 1) begin
        adc_valid = 1'b1;
        adc_data  = 12'hFFE;
      end
      if (v.disturb && busy_cycles == 5) start = 1'b1;

      if (adc_req) begin
        reqs++;
        if (exp_pos_q.size() == 0) begin
          check("req_unexpected", reqs, THETA_N * PHI_N);
        end else begin
          ep = exp_pos_q.pop_front();
          check("req_theta", theta_pos, ep.t);
          check("req_phi", phi_pos, ep.p);
          if (silent00 && ep.t == 8'd0 && ep.p == 8'd0) tmo_cnt = 0;
          else begin
            pend      = v.lat;
            pend_data = adc_model(v, ep.t, ep.p);
          end
        end
      end

      if (pend == 0) begin
        adc_valid = 1'b1;
        adc_data  = pend_data;
        pend      = -1;
      end else if (pend > 0) begin
        pend--;
      end

      if (done) begin
        finished = 1;
        er = exp_res_q.pop_front();
        check("sweep_length", busy_cycles, exp_busy);
        check("req_count", reqs, THETA_N * PHI_N);
        check("positions_left", exp_pos_q.size(), 0);
        check("best_value", best_value, er.v);
        check("best_theta", best_theta, er.t);
        check("best_phi", best_phi, er.p);
        check("park_theta", theta_pos, er.t);
        check("park_phi", phi_pos, er.p);
        check("timeout_err_end", timeout_err, silent00);
      end else begin
        @(negedge clk);
      end
    end
    check("sweep_finish", finished, 1);
    exp_pos_q.delete();

    // done is a single pulse, the stray start must not have been queued,
    // and results hold while idle.
    for (int i = 0; i < 3; i++) begin
      adc_valid = 1'b0;
      start     = 1'b0;
      @(negedge clk);
      check("idle_done_low", done, 0);
      check("idle_busy_low", busy, 0);
    end
    check("hold_theta", theta_pos, cur_res.t);
    check("hold_value", best_value, cur_res.v);
  endtask

  vec_t vecs[6];
  vec_t vt;
  bit   seen;

  initial begin
    vecs[0] = '{12'd100, 8'd2, 8'd1, 12'd900, 8'd9, 8'd9, 12'd0,    2, 1'b0, 12'd900,  8'd2, 8'd1};
    vecs[1] = '{12'd100, 8'd1, 8'd0, 12'd500, 8'd3, 8'd1, 12'd500,  1, 1'b0, 12'd500,  8'd1, 8'd0};
    vecs[2] = '{12'd100, 8'd2, 8'd1, 12'd900, 8'd9, 8'd9, 12'd0,    1, 1'b1, 12'd900,  8'd2, 8'd1};
    vecs[3] = '{12'd0,   8'd3, 8'd0, 12'hFFF, 8'd9, 8'd9, 12'd0,    0, 1'b0, 12'd4095, 8'd3, 8'd0};
    vecs[4] = '{12'd0,   8'd9, 8'd9, 12'd0,   8'd9, 8'd9, 12'd0,    0, 1'b0, 12'd0,    8'd0, 8'd0};
    vecs[5] = '{12'd7,   8'd3, 8'd1, 12'd4094, 8'd0, 8'd0, 12'd4093, 3, 1'b0, 12'd4094, 8'd3, 8'd1};

    reset     = 1'b1;
    start     = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", adc_req, 0);
    check("rst_theta", theta_pos, 0);
    check("rst_phi", phi_pos, 0);
    check("rst_best", best_value, 0);
    check("rst_err", timeout_err, 0);

    // reset wins over a simultaneous start
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check("rst_over_start", busy, 0);
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_sweep(vecs[i], 1'b0);

    // Reset in the middle of SETTLE at point (3,1)
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    for (int cyc = 0; cyc < 500 && !seen; cyc++) begin
      adc_valid = 1'b0;
      if (theta_pos == 8'd3 && phi_pos == 8'd1) seen = 1;
      else begin
        if (adc_req) begin
          adc_valid = 1'b1;
          adc_data  = 12'd50;
        end
        @(negedge clk);
      end
    end
    check("reach_point_31", seen, 1);
    @(negedge clk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_best", best_value, 50);
    reset     = 1'b1;
    start     = 1'b1;
    adc_valid = 1'b1;
    adc_data  = 12'hFFF;
    @(negedge clk);
    reset     = 1'b0;
    start     = 1'b0;
    adc_valid = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_theta", theta_pos, 0);
    check("mid_rst_phi", phi_pos, 0);
    check("mid_rst_best", best_value, 0);
    check("mid_rst_done", done, 0);
    repeat (3) @(negedge clk);
    check("mid_rst_stays_idle", busy, 0);

    // sweep after the mid-sweep reset runs normally
    run_sweep(vecs[0], 1'b0);

`ifdef SWEEP_TIMEOUT_EN
    vt = '{12'd100, 8'd9, 8'd9, 12'd0, 8'd9, 8'd9, 12'd0, 0, 1'b0, 12'd100, 8'd1, 8'd0};
    run_sweep(vt, 1'b1);
    check("err_sticky_idle", timeout_err, 1);
    // next start clears the flag (checked at the first busy cycle)
    run_sweep(vecs[3], 1'b0);
`else
    vt = vecs[1];
    run_sweep(vt, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
